// File: rtl/uart_pkg.sv
// Shared types and constants for the word-oriented 8N1 UART transmitter.
// Holds the byte FSM state encoding and the word-to-byte selection helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [7:0] UART_NEWLINE   = 8'h0A;
    localparam int         FRAME_BITS     = 10;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         DATA_BITS      = FRAME_BITS - 2;

    // Byte 0 is the most-significant byte; any index past the word is the terminator.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] sel;
        case (idx)
            3'd0:    sel = word[31:24];
            3'd1:    sel = word[23:16];
            3'd2:    sel = word[15:8];
            3'd3:    sel = word[7:0];
            default: sel = UART_NEWLINE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A start request on the last cycle of the stop bit
// chains the next frame with no idle gap; o_done pulses only when the line goes idle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_idle,
    output logic       o_last_tick,
    output logic       o_tx,
    output logic       o_done
);
    import uart_pkg::*;

    localparam int              CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic             bit_end;
    logic [2:0]       bit_idx_next;

    assign bit_end      = (baud_cnt_q == CNT_MAX);
    assign bit_idx_next = bit_idx_q + 3'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (i_start) begin
                    state_d = START;
                    data_d  = i_data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_next;
                        tx_d      = data_q[bit_idx_next];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (i_start) begin
                        state_d = START;
                        data_d  = i_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            data_q     <= 8'h00;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign o_idle      = (state_q == IDLE);
    assign o_last_tick = (state_q == STOP) && bit_end;
    assign o_tx        = tx_q;
    assign o_done      = done_q;

endmodule

// File: rtl/uart_word_tx.sv
// 32-bit word transmitter: sends the word MSB byte first as back-to-back 8N1 frames.
// Define UART_TX_NEWLINE_EN to append an 8'h0A terminator frame after the last byte.
module uart_word_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_word,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);
    import uart_pkg::*;

`ifdef UART_TX_NEWLINE_EN
    localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD);
`else
    localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);
`endif

    logic [31:0] word_q, word_d;
    logic [2:0]  byte_idx_q, byte_idx_d;

    logic        tx_idle;
    logic        tx_last_tick;
    logic        accept;
    logic        more_bytes;
    logic        byte_start;
    logic [7:0]  byte_data;

    always_comb begin
        accept     = i_valid && tx_idle;
        more_bytes = (byte_idx_q != LAST_IDX);

        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        byte_start = 1'b0;
        byte_data  = word_byte(word_q, byte_idx_q + 3'd1);

        if (accept) begin
            word_d     = i_word;
            byte_idx_d = 3'd0;
            byte_start = 1'b1;
            byte_data  = word_byte(i_word, 3'd0);
        end else if (tx_last_tick && more_bytes) begin
            // Hand the next byte over during the final stop-bit cycle so frames abut.
            byte_idx_d = byte_idx_q + 3'd1;
            byte_start = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= 32'h0;
            byte_idx_q <= 3'd0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .i_start    (byte_start),
        .i_data     (byte_data),
        .o_idle     (tx_idle),
        .o_last_tick(tx_last_tick),
        .o_tx       (o_tx),
        .o_done     (o_done)
    );

    assign o_ready = tx_idle;
    assign o_busy  = !tx_idle;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at 4 clocks per bit, with a UART line decoder.
// Honours UART_TX_NEWLINE_EN the same way as the design.
module tb_uart_word_tx;

    localparam int C = 4;
`ifdef UART_TX_NEWLINE_EN
    localparam int LAT = 50 * C;
    localparam bit NL  = 1'b1;
`else
    localparam int LAT = 40 * C;
    localparam bit NL  = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] i_word;
    logic        i_valid;
    logic        o_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int          n_checks;
    int          n_errors;
    int          cycle;
    int          done_cnt;
    int          frame_err;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    uart_word_tx #(
        .CLK_FREQ    (400),
        .BAUD        (100),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_word (i_word),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (o_done === 1'b1) done_cnt = done_cnt + 1;
        end
    end

    // Line decoder: samples each bit at its centre, drops partial frames on reset.
    initial begin : uart_model
        bit         active;
        int         cnt;
        logic [7:0] sh;
        active    = 1'b0;
        cnt       = 0;
        sh        = 8'h00;
        frame_err = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (o_tx === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt = cnt + 1;
                if (cnt == C / 2) begin
                    if (o_tx !== 1'b0) active = 1'b0;
                end else if (cnt % C == C / 2) begin
                    if (cnt / C <= 8) begin
                        sh = {o_tx, sh[7:1]};
                    end else begin
                        if (o_tx === 1'b1) rx_q.push_back(sh);
                        else frame_err = frame_err + 1;
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic send_word(input logic [31:0] w, output int acc);
        @(posedge clk);
        #1;
        i_word  = w;
        i_valid = 1'b1;
        acc     = cycle + 1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                ok = 1'b1;
                at = cycle;
            end
        end
    endtask

    task automatic compare_rx(input string name);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s byte count: got %0d expected %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL %s byte %0d: got %h expected %h", name, i, rx_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (frame_err != 0) begin
            n_errors++;
            $display("FAIL %s framing: got %0d errors expected 0", name, frame_err);
        end
    endtask

    task automatic test_reset();
        int bad;
        int d0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_word  = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b1) begin n_errors++; $display("FAIL reset o_tx: got %b expected 1", o_tx); end
        n_checks++;
        if (o_ready !== 1'b1) begin n_errors++; $display("FAIL reset o_ready: got %b expected 1", o_ready); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset o_busy: got %b expected 0", o_busy); end
        n_checks++;
        if (o_done !== 1'b0) begin n_errors++; $display("FAIL reset o_done: got %b expected 0", o_done); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0  = done_cnt;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL idle100 bad cycles: got %0d expected 0", bad); end
        n_checks++;
        if (done_cnt != d0) begin n_errors++; $display("FAIL idle100 done pulses: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_single_word();
        int acc;
        int at;
        bit ok;
        rx_q.delete();
        frame_err = 0;
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        if (NL) exp_q.push_back(8'h0A);
        send_word(32'h41424344, acc);
        @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b0) begin n_errors++; $display("FAIL single start latency o_tx: got %b expected 0", o_tx); end
        n_checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            n_errors++; $display("FAIL single busy/ready: got %b/%b expected 1/0", o_busy, o_ready);
        end
        wait_done(LAT + 50, ok, at);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL single done timeout: got none expected pulse"); end
        n_checks++;
        if (at - acc != LAT) begin n_errors++; $display("FAIL single done latency: got %0d expected %0d", at - acc, LAT); end
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL single ready at done: got %b/%b expected 1/0", o_ready, o_busy);
        end
        @(negedge clk);
        n_checks++;
        if (o_done !== 1'b0) begin n_errors++; $display("FAIL single done width: got %b expected 0", o_done); end
        if (rx_q.size() >= 4) $display("decoded word %h%h%h%h", rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
        compare_rx("single");
    endtask

    task automatic test_pattern();
        int acc;
        int at;
        bit ok;
        rx_q.delete();
        frame_err = 0;
        exp_q = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        if (NL) exp_q.push_back(8'h0A);
        send_word(32'h00FF55AA, acc);
        wait_done(LAT + 50, ok, at);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL pattern done timeout: got none expected pulse"); end
        n_checks++;
        if (at - acc != LAT) begin n_errors++; $display("FAIL pattern done latency: got %0d expected %0d", at - acc, LAT); end
        repeat (2 * C) @(negedge clk);
        compare_rx("pattern");
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        int at;
        bit ok;
        rx_q.delete();
        frame_err = 0;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        if (NL) exp_q.push_back(8'h0A);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        if (NL) exp_q.push_back(8'h0A);
        @(posedge clk);
        #1;
        i_word  = 32'h11223344;
        i_valid = 1'b1;
        acc1    = cycle + 1;
        @(posedge clk);
        #1;
        i_word = 32'h55667788;
        wait_done(LAT + 50, ok, at);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL b2b first done timeout: got none expected pulse"); end
        n_checks++;
        if (at - acc1 != LAT) begin n_errors++; $display("FAIL b2b first latency: got %0d expected %0d", at - acc1, LAT); end
        n_checks++;
        if (o_tx !== 1'b1 || o_ready !== 1'b1) begin
            n_errors++; $display("FAIL b2b idle cycle tx/ready: got %b/%b expected 1/1", o_tx, o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        acc2    = cycle;
        @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
            n_errors++; $display("FAIL b2b second accept tx/busy: got %b/%b expected 0/1", o_tx, o_busy);
        end
        wait_done(LAT + 50, ok, at);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL b2b second done timeout: got none expected pulse"); end
        n_checks++;
        if (at - acc2 != LAT) begin n_errors++; $display("FAIL b2b second latency: got %0d expected %0d", at - acc2, LAT); end
        repeat (2 * C) @(negedge clk);
        compare_rx("b2b");
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        int at;
        int d0;
        int bad;
        bit ok;
        rx_q.delete();
        frame_err = 0;
        send_word(32'h0F0F0F0F, acc);
        while (cycle < acc + 29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0  = done_cnt;
        @(negedge clk);
        n_checks++;
        if (o_tx !== 1'b1) begin n_errors++; $display("FAIL abort o_tx: got %b expected 1", o_tx); end
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL abort ready/busy: got %b/%b expected 1/0", o_ready, o_busy);
        end
        bad = 0;
        repeat (LAT + 20) begin
            @(negedge clk);
            if (o_tx !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL abort line activity: got %0d low cycles expected 0", bad); end
        n_checks++;
        if (done_cnt != d0) begin n_errors++; $display("FAIL abort done pulses: got %0d expected 0", done_cnt - d0); end
        n_checks++;
        if (rx_q.size() != 0) begin n_errors++; $display("FAIL abort bytes: got %0d expected 0", rx_q.size()); end
        rx_q.delete();
        frame_err = 0;
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        if (NL) exp_q.push_back(8'h0A);
        send_word(32'hDEADBEEF, acc);
        wait_done(LAT + 50, ok, at);
        n_checks++;
        if (!ok || at - acc != LAT) begin
            n_errors++; $display("FAIL recover done latency: got %0d expected %0d", at - acc, LAT);
        end
        repeat (2 * C) @(negedge clk);
        compare_rx("recover");
    endtask

    task automatic test_busy_ignore();
        int acc;
        int at;
        int d0;
        bit ok;
        rx_q.delete();
        frame_err = 0;
        exp_q = '{8'h13, 8'h57, 8'h9B, 8'hDF};
        if (NL) exp_q.push_back(8'h0A);
        send_word(32'h13579BDF, acc);
        repeat (50) @(posedge clk);
        #1;
        i_word  = 32'hCAFEF00D;
        i_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b0) begin n_errors++; $display("FAIL ignore ready while busy: got %b expected 0", o_ready); end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_done(LAT + 50, ok, at);
        n_checks++;
        if (!ok || at - acc != LAT) begin
            n_errors++; $display("FAIL ignore done latency: got %0d expected %0d", at - acc, LAT);
        end
        d0 = done_cnt;
        repeat (LAT + 20) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || o_ready !== 1'b1) begin
            n_errors++; $display("FAIL ignore extra activity: got %0d pulses ready %b expected 0 pulses ready 1", done_cnt - d0, o_ready);
        end
        compare_rx("ignore");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_word   = 32'h0;
        test_reset();
        test_single_word();
        test_pattern();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
